// File: rtl/wc_fifo_ctrl_if.sv
// Handshake and RAM-control bundle between the FIFO controller and its
// producer/consumer side.
interface wc_fifo_ctrl_if #(
  parameter int AW_IN  = 5,
  parameter int AW_OUT = 7
);
  localparam int AW_MAX = (AW_IN > AW_OUT) ? AW_IN : AW_OUT;

  logic              FLUSH;
  logic              PUSH;
  logic              PUSH_RDY;
  logic              POP;
  logic              POP_RDY;
  logic              RAM_WR_EN;
  logic [AW_IN-1:0]  RAM_ADDR_WR;
  logic              RAM_RD_EN;
  logic [AW_OUT-1:0] RAM_ADDR_RD;
  logic              Q_VALID;
  logic [AW_MAX:0]   COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;

  modport master (
    output FLUSH,
    output PUSH,
    output POP,
    input  PUSH_RDY,
    input  POP_RDY,
    input  RAM_WR_EN,
    input  RAM_ADDR_WR,
    input  RAM_RD_EN,
    input  RAM_ADDR_RD,
    input  Q_VALID,
    input  COUNT,
    input  OVERFLOW,
    input  UNDERFLOW
  );

  modport slave (
    input  FLUSH,
    input  PUSH,
    input  POP,
    output PUSH_RDY,
    output POP_RDY,
    output RAM_WR_EN,
    output RAM_ADDR_WR,
    output RAM_RD_EN,
    output RAM_ADDR_RD,
    output Q_VALID,
    output COUNT,
    output OVERFLOW,
    output UNDERFLOW
  );
endinterface

// File: rtl/wc_fifo_ctrl.sv
// Width-converting FIFO controller: drives a dual-port RAM with DW_IN-bit
// writes and DW_OUT-bit reads, tracking occupancy in narrow-word units.
module wc_fifo_ctrl #(
  parameter int AW_IN  = 5,
  parameter int AW_OUT = 7,
  parameter int DW_IN  = 64,
  parameter int DW_OUT = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  wc_fifo_ctrl_if.slave bus
);
  localparam int DW_N   = (DW_IN < DW_OUT) ? DW_IN : DW_OUT;
  localparam int W_INC  = DW_IN / DW_N;
  localparam int R_DEC  = DW_OUT / DW_N;
  localparam int AW_MAX = (AW_IN > AW_OUT) ? AW_IN : AW_OUT;
  localparam int CW     = AW_MAX + 1;
  localparam int CAP    = 1 << AW_MAX;

  localparam logic [CW-1:0] PUSH_LIM = CW'(CAP - W_INC);
  localparam logic [CW-1:0] POP_LIM  = CW'(R_DEC);
  localparam logic [CW-1:0] INC      = CW'(W_INC);
  localparam logic [CW-1:0] DEC      = CW'(R_DEC);

  logic [AW_IN-1:0]  wr_ptr;
  logic [AW_OUT-1:0] rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              q_vld;
  logic              ovf;
  logic              udf;
  logic              push_rdy;
  logic              pop_rdy;
  logic              push_acc;
  logic              pop_acc;

  // Readiness looks only at the registered count, never at this cycle's ops.
  assign push_rdy = (cnt <= PUSH_LIM);
  assign pop_rdy  = (cnt >= POP_LIM);

  assign push_acc = RST_N & bus.PUSH & push_rdy & ~bus.FLUSH;
  assign pop_acc  = RST_N & bus.POP & pop_rdy & ~bus.FLUSH;

  always_comb begin
    cnt_next = cnt;
    if (push_acc)
      cnt_next = cnt_next + INC;
    if (pop_acc)
      cnt_next = cnt_next - DEC;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      q_vld  <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (bus.FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      q_vld  <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_acc)
        wr_ptr <= wr_ptr + AW_IN'(1);
      if (pop_acc)
        rd_ptr <= rd_ptr + AW_OUT'(1);
      cnt   <= cnt_next;
      q_vld <= pop_acc;
      if (bus.PUSH && !push_rdy)
        ovf <= 1'b1;
      if (bus.POP && !pop_rdy)
        udf <= 1'b1;
    end
  end

  assign bus.PUSH_RDY    = push_rdy;
  assign bus.POP_RDY     = pop_rdy;
  assign bus.RAM_WR_EN   = push_acc;
  assign bus.RAM_ADDR_WR = wr_ptr;
  assign bus.RAM_RD_EN   = pop_acc;
  assign bus.RAM_ADDR_RD = rd_ptr;
  assign bus.Q_VALID     = q_vld;
  assign bus.COUNT       = cnt;
  assign bus.OVERFLOW    = ovf;
  assign bus.UNDERFLOW   = udf;
endmodule

// File: tb/tb_wc_fifo_ctrl.sv
// Directed bench for wc_fifo_ctrl with a narrow-word RAM model and a
// scoreboard monitor that checks every word presented on Q_VALID.
module tb_wc_fifo_ctrl;
  logic clk;
  logic rst_n;

  wc_fifo_ctrl_if #(.AW_IN(5), .AW_OUT(7)) bus ();

  wc_fifo_ctrl #(
    .AW_IN(5), .AW_OUT(7), .DW_IN(64), .DW_OUT(16)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] wdata;
  logic [15:0] mem [128];
  logic [15:0] q;

  always @(posedge clk) begin
    if (bus.RAM_WR_EN)
      for (int i = 0; i < 4; i++)
        mem[{bus.RAM_ADDR_WR, 2'(i)}] <= wdata[16*i +: 16];
    if (bus.RAM_RD_EN)
      q <= mem[bus.RAM_ADDR_RD];
  end

  int total = 0;
  int bad = 0;
  logic [15:0] sb [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.Q_VALID) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL q_unexp: got %0h want none", q);
      end else begin
        chk("q_data", {48'd0, q}, {48'd0, sb.pop_front()});
      end
    end
  end

  logic       wr_en_s;
  logic       rd_en_s;
  logic [4:0] addr_wr_s;
  logic [6:0] addr_rd_s;

  task automatic step(input logic push, input logic pop,
                      input logic flush, input logic [63:0] d);
    bus.PUSH  = push;
    bus.POP   = pop;
    bus.FLUSH = flush;
    wdata     = d;
    @(negedge clk);
    wr_en_s   = bus.RAM_WR_EN;
    rd_en_s   = bus.RAM_RD_EN;
    addr_wr_s = bus.RAM_ADDR_WR;
    addr_rd_s = bus.RAM_ADDR_RD;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] d);
    for (int i = 0; i < 4; i++)
      sb.push_back(d[16*i +: 16]);
  endtask

  task automatic do_flush(input logic push);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    sb.delete();
    step(push, 1'b0, 1'b1, 64'hdead_beef_dead_beef);
    chk("flush_wr_en", {63'd0, wr_en_s}, 64'd0);
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [15:0] b;
    b = 16'(i * 4) + 16'h1000;
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  initial begin
    int k;
    int j;
    bus.PUSH  = 1'b0;
    bus.POP   = 1'b0;
    bus.FLUSH = 1'b0;
    wdata     = '0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;

    // reset held with both requests asserted
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 64'hffff_ffff_ffff_ffff);
      chk("rst_wr_en", {63'd0, wr_en_s}, 64'd0);
      chk("rst_rd_en", {63'd0, rd_en_s}, 64'd0);
    end
    chk("rst_count", 64'(bus.COUNT), 64'd0);
    chk("rst_push_rdy", {63'd0, bus.PUSH_RDY}, 64'd1);
    chk("rst_pop_rdy", {63'd0, bus.POP_RDY}, 64'd0);
    chk("rst_q_valid", {63'd0, bus.Q_VALID}, 64'd0);
    chk("rst_ovf", {63'd0, bus.OVERFLOW}, 64'd0);
    chk("rst_udf", {63'd0, bus.UNDERFLOW}, 64'd0);
    bus.PUSH = 1'b0;
    bus.POP  = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 1'b0, 1'b0, 64'd0);

    // fill to capacity
    for (int i = 0; i < 32; i++) begin
      push_exp(pat(i));
      step(1'b1, 1'b0, 1'b0, pat(i));
      chk("fill_wr_en", {63'd0, wr_en_s}, 64'd1);
      chk("fill_addr_wr", 64'(addr_wr_s), 64'(i));
    end
    chk("full_count", 64'(bus.COUNT), 64'd128);
    chk("full_push_rdy", {63'd0, bus.PUSH_RDY}, 64'd0);
    step(1'b1, 1'b0, 1'b0, 64'h5555_5555_5555_5555);
    chk("ovf_wr_en", {63'd0, wr_en_s}, 64'd0);
    chk("ovf_flag", {63'd0, bus.OVERFLOW}, 64'd1);
    chk("ovf_count", 64'(bus.COUNT), 64'd128);

    for (int i = 0; i < 128; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'd0);
      chk("drain_addr_rd", 64'(addr_rd_s), 64'(i));
    end
    step(1'b0, 1'b0, 1'b0, 64'd0);
    chk("drain_count", 64'(bus.COUNT), 64'd0);
    chk("drain_pop_rdy", {63'd0, bus.POP_RDY}, 64'd0);

    // ordering of narrow words
    do_flush(1'b0);
    push_exp(64'h0004_0003_0002_0001);
    step(1'b1, 1'b0, 1'b0, 64'h0004_0003_0002_0001);
    chk("ord_qv_idle", {63'd0, bus.Q_VALID}, 64'd0);
    chk("ord_pop_rdy", {63'd0, bus.POP_RDY}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'd0);
      chk("ord_rd_en", {63'd0, rd_en_s}, 64'd1);
      chk("ord_addr_rd", 64'(addr_rd_s), 64'(i));
      chk("ord_q_valid", {63'd0, bus.Q_VALID}, 64'd1);
    end
    chk("ord_empty", {63'd0, bus.POP_RDY}, 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'd0);
    chk("udf_rd_en", {63'd0, rd_en_s}, 64'd0);
    chk("udf_flag", {63'd0, bus.UNDERFLOW}, 64'd1);
    chk("udf_q_valid", {63'd0, bus.Q_VALID}, 64'd0);

    // simultaneous push and pop near full
    do_flush(1'b0);
    for (int i = 0; i < 32; i++) begin
      push_exp(pat(i + 40));
      step(1'b1, 1'b0, 1'b0, pat(i + 40));
    end
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 64'd0);
    chk("sim_count125", 64'(bus.COUNT), 64'd125);
    step(1'b1, 1'b1, 1'b0, 64'h7777_7777_7777_7777);
    chk("sim125_wr_en", {63'd0, wr_en_s}, 64'd0);
    chk("sim125_rd_en", {63'd0, rd_en_s}, 64'd1);
    chk("sim_count124", 64'(bus.COUNT), 64'd124);
    chk("sim_ovf", {63'd0, bus.OVERFLOW}, 64'd1);
    push_exp(pat(90));
    step(1'b1, 1'b1, 1'b0, pat(90));
    chk("sim124_wr_en", {63'd0, wr_en_s}, 64'd1);
    chk("sim124_rd_en", {63'd0, rd_en_s}, 64'd1);
    chk("sim_count127", 64'(bus.COUNT), 64'd127);
    for (int i = 0; i < 127; i++)
      step(1'b0, 1'b1, 1'b0, 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    chk("sim_drained", 64'(bus.COUNT), 64'd0);

    // pointer wrap-around
    do_flush(1'b0);
    k = 0;
    j = 0;
    for (int it = 0; it < 40; it++) begin
      push_exp(pat(it + 100));
      step(1'b1, 1'b0, 1'b0, pat(it + 100));
      chk("wrap_addr_wr", 64'(addr_wr_s), 64'(k % 32));
      k++;
      for (int p = 0; p < 4; p++) begin
        step(1'b0, 1'b1, 1'b0, 64'd0);
        chk("wrap_addr_rd", 64'(addr_rd_s), 64'(j % 128));
        j++;
      end
    end
    step(1'b0, 1'b0, 1'b0, 64'd0);
    chk("wrap_count", 64'(bus.COUNT), 64'd0);

    // flush with pending data and a push in the same cycle
    step(1'b0, 1'b1, 1'b0, 64'd0);
    for (int i = 0; i < 15; i++) begin
      push_exp(pat(i + 200));
      step(1'b1, 1'b0, 1'b0, pat(i + 200));
    end
    chk("fl_count60", 64'(bus.COUNT), 64'd60);
    chk("fl_udf_pre", {63'd0, bus.UNDERFLOW}, 64'd1);
    do_flush(1'b1);
    chk("fl_count", 64'(bus.COUNT), 64'd0);
    chk("fl_push_rdy", {63'd0, bus.PUSH_RDY}, 64'd1);
    chk("fl_pop_rdy", {63'd0, bus.POP_RDY}, 64'd0);
    chk("fl_ovf", {63'd0, bus.OVERFLOW}, 64'd0);
    chk("fl_udf", {63'd0, bus.UNDERFLOW}, 64'd0);
    chk("fl_q_valid", {63'd0, bus.Q_VALID}, 64'd0);
    push_exp(64'h0a0d_0c0c_0b0b_0a0a);
    step(1'b1, 1'b0, 1'b0, 64'h0a0d_0c0c_0b0b_0a0a);
    chk("fl_addr_wr", 64'(addr_wr_s), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'd0);
      chk("fl_addr_rd", 64'(addr_rd_s), 64'(i));
    end
    step(1'b0, 1'b0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
